xf100_dtcm_resp: RTL and testbench

Data-RAM responder for the xf100 execute stage. It is the RAM-side end of the AGU data-RAM port: it accepts byte-addressed load/store requests, realigns byte lanes to the word-organised storage, and returns realigned read data one cycle later. After reset it runs an automatic zero-fill of the whole array before accepting traffic. It sits between the EXU AGU and the four byte-wide data-RAM banks.

---
 rtl/xf100_dtcm_resp_pkg.sv | 25 ++
 rtl/xf100_dtcm_resp_if.sv | 37 +++
 rtl/xf100_dtcm_resp_bank.sv | 28 ++
 rtl/xf100_dtcm_resp.sv | 124 ++++++++++++
 tb/tb_xf100_dtcm_resp.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/xf100_dtcm_resp_pkg.sv
// rtl/xf100_dtcm_resp_pkg.sv - shared constants, FSM encoding and misalign helper for the DTCM responder
package xf100_dtcm_resp_pkg;

  localparam int XF100_DATA_RAM_AW = 8;
  localparam int DTCM_LANES        = 4;
  localparam int DTCM_OFF_W        = 2;
  localparam int DTCM_SUM_W        = 3;

  typedef enum logic [0:0] {
    DTCM_ST_INIT = 1'b0,
    DTCM_ST_RUN  = 1'b1
  } dtcm_state_e;

  // A request is misaligned when its highest enabled lane lands past byte 3 of the word.
  function automatic logic dtcm_misaligned(input logic [DTCM_OFF_W-1:0] off,
                                           input logic [DTCM_LANES-1:0] mask);
    logic [DTCM_SUM_W-1:0] hi;
    hi = '0;
    for (int k = 0; k < DTCM_LANES; k++) begin
      if (mask[k]) hi = DTCM_SUM_W'(k);
    end
    return ({1'b0, off} + hi) > DTCM_SUM_W'(3);
  endfunction

endpackage

// File: rtl/xf100_dtcm_resp_if.sv
// rtl/xf100_dtcm_resp_if.sv - AGU data-RAM port bundle (AGU master, RAM slave)
interface xf100_dtcm_resp_if
  import xf100_dtcm_resp_pkg::*;
#(
  parameter int RAM_AW = XF100_DATA_RAM_AW
);
  logic              ram_i_cs;
  logic              ram_i_wen;
  logic [3:0]        ram_i_mask;
  logic [RAM_AW-1:0] ram_i_addr;
  logic [7:0]        ram_i_wdat0;
  logic [7:0]        ram_i_wdat1;
  logic [7:0]        ram_i_wdat2;
  logic [7:0]        ram_i_wdat3;
  logic [7:0]        ram_o_rdat0;
  logic [7:0]        ram_o_rdat1;
  logic [7:0]        ram_o_rdat2;
  logic [7:0]        ram_o_rdat3;
  logic              ram_o_rvalid;
  logic              ram_o_ready;
  logic              ram_o_err;

  modport master (
    output ram_i_cs, ram_i_wen, ram_i_mask, ram_i_addr,
           ram_i_wdat0, ram_i_wdat1, ram_i_wdat2, ram_i_wdat3,
    input  ram_o_rdat0, ram_o_rdat1, ram_o_rdat2, ram_o_rdat3,
           ram_o_rvalid, ram_o_ready, ram_o_err
  );

  modport slave (
    input  ram_i_cs, ram_i_wen, ram_i_mask, ram_i_addr,
           ram_i_wdat0, ram_i_wdat1, ram_i_wdat2, ram_i_wdat3,
    output ram_o_rdat0, ram_o_rdat1, ram_o_rdat2, ram_o_rdat3,
           ram_o_rvalid, ram_o_ready, ram_o_err
  );

endinterface

// File: rtl/xf100_dtcm_resp_bank.sv
// rtl/xf100_dtcm_resp_bank.sv - one byte-wide single-port synchronous RAM bank with registered read
module xf100_dtcm_bank #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read register only moves on a read, so the last load result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= 8'h00;
    else if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/xf100_dtcm_resp.sv
// rtl/xf100_dtcm_resp.sv - DTCM responder: lane rotation, misalign check, zero-fill FSM, response registers
module xf100_dtcm_resp
  import xf100_dtcm_resp_pkg::*;
#(
  parameter int RAM_AW = XF100_DATA_RAM_AW
) (
  input logic               clk,
  input logic               rst_n,
  xf100_dtcm_resp_if.slave  bus
);
  localparam int WW = RAM_AW - 2;
  localparam logic [WW-1:0] LAST_WORD = {WW{1'b1}};

  dtcm_state_e   r_state;
  logic [WW-1:0] r_cnt;
  logic          r_ready;
  logic          r_rvalid;
  logic          r_err;
  logic [1:0]    r_rd_off;
  logic [3:0]    r_rd_mask;

  logic [1:0]    w_off;
  logic [WW-1:0] w_word;
  logic          w_acc;
  logic          w_mis;
  logic          w_load;
  logic          w_store;
  logic [7:0]    w_wdat    [DTCM_LANES];
  logic [3:0]    w_bank_we;
  logic [7:0]    w_bank_wd [DTCM_LANES];
  logic [WW-1:0] w_bank_addr;
  logic [7:0]    w_bank_q  [DTCM_LANES];
  logic [7:0]    w_rdat    [DTCM_LANES];

  assign w_off   = bus.ram_i_addr[1:0];
  assign w_word  = bus.ram_i_addr[RAM_AW-1:2];
  assign w_acc   = bus.ram_i_cs & r_ready & (|bus.ram_i_mask);
  assign w_mis   = dtcm_misaligned(w_off, bus.ram_i_mask);
  assign w_load  = w_acc & ~w_mis & ~bus.ram_i_wen;
  assign w_store = w_acc & ~w_mis & bus.ram_i_wen;

  assign w_wdat[0] = bus.ram_i_wdat0;
  assign w_wdat[1] = bus.ram_i_wdat1;
  assign w_wdat[2] = bus.ram_i_wdat2;
  assign w_wdat[3] = bus.ram_i_wdat3;

  // Zero-fill owns every bank until ready; afterwards request lane k steers to bank off+k.
  always_comb begin
    logic [1:0] lane;
    lane        = 2'd0;
    w_bank_we   = 4'h0;
    w_bank_addr = w_word;
    for (int b = 0; b < DTCM_LANES; b++) w_bank_wd[b] = 8'h00;
    if (!r_ready) begin
      w_bank_we   = 4'hF;
      w_bank_addr = r_cnt;
    end else begin
      for (int k = 0; k < DTCM_LANES; k++) begin
        lane = w_off + 2'(k);
        if (w_store && bus.ram_i_mask[k]) begin
          w_bank_we[lane] = 1'b1;
          w_bank_wd[lane] = w_wdat[k];
        end
      end
    end
  end

  for (genvar g = 0; g < DTCM_LANES; g++) begin : g_bank
    xf100_dtcm_bank #(.AW(WW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_bank_we[g]),
      .i_re    (w_load),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wd[g]),
      .o_rdata (w_bank_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DTCM_ST_INIT;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rd_off  <= 2'd0;
      r_rd_mask <= 4'h0;
    end else begin
      r_rvalid <= w_load;
      r_err    <= w_acc & w_mis;
      if (w_load) begin
        r_rd_off  <= w_off;
        r_rd_mask <= bus.ram_i_mask;
      end
      case (r_state)
        DTCM_ST_INIT: begin
          if (r_cnt == LAST_WORD) begin
            r_state <= DTCM_ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < DTCM_LANES; k++) begin
      w_rdat[k] = r_rd_mask[k] ? w_bank_q[r_rd_off + 2'(k)] : 8'h00;
    end
  end

  assign bus.ram_o_rdat0  = w_rdat[0];
  assign bus.ram_o_rdat1  = w_rdat[1];
  assign bus.ram_o_rdat2  = w_rdat[2];
  assign bus.ram_o_rdat3  = w_rdat[3];
  assign bus.ram_o_rvalid = r_rvalid;
  assign bus.ram_o_ready  = r_ready;
  assign bus.ram_o_err    = r_err;

endmodule

// File: tb/tb_xf100_dtcm_resp.sv
// tb/tb_xf100_dtcm_resp.sv - vector table, directed corner sequences and random traffic vs byte-array model
module tb_xf100_dtcm_resp;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  xf100_dtcm_resp_if #(.RAM_AW(AW)) bus ();

  xf100_dtcm_resp #(.RAM_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [7:0] m_mem [0:(1<<AW)-1];
  logic [7:0] m_rdat [4];
  int         m_cycles;

  typedef struct {
    logic        cs;
    logic        wen;
    logic [3:0]  mask;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic        rv;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_rdat();
    return {bus.ram_o_rdat3, bus.ram_o_rdat2, bus.ram_o_rdat1, bus.ram_o_rdat0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = 8'h00;
    for (int k = 0; k < 4; k++) m_rdat[k] = 8'h00;
    m_cycles = 0;
  endtask

  task automatic do_req(input logic cs, input logic wen, input logic [3:0] mask,
                        input logic [7:0] addr, input logic [31:0] wdat);
    logic exp_rv, exp_err, rdy;
    int   hi;
    bus.ram_i_cs = cs;   bus.ram_i_wen = wen;  bus.ram_i_mask = mask; bus.ram_i_addr = addr;
    bus.ram_i_wdat0 = wdat[7:0];   bus.ram_i_wdat1 = wdat[15:8];
    bus.ram_i_wdat2 = wdat[23:16]; bus.ram_i_wdat3 = wdat[31:24];
    rdy = (m_cycles >= DEPTH);
    @(posedge clk);
    exp_rv = 1'b0;
    exp_err = 1'b0;
    if (cs && rdy && mask != 4'h0) begin
      hi = 0;
      for (int k = 0; k < 4; k++) if (mask[k]) hi = k;
      if (int'(addr[1:0]) + hi > 3) exp_err = 1'b1;
      else if (wen) begin
        for (int k = 0; k < 4; k++) if (mask[k]) m_mem[int'(addr) + k] = wdat[8*k +: 8];
      end else begin
        exp_rv = 1'b1;
        for (int k = 0; k < 4; k++) m_rdat[k] = mask[k] ? m_mem[int'(addr) + k] : 8'h00;
      end
    end
    m_cycles++;
    #1;
    chk("rvalid", {31'b0, bus.ram_o_rvalid}, {31'b0, exp_rv});
    chk("err", {31'b0, bus.ram_o_err}, {31'b0, exp_err});
    chk("ready", {31'b0, bus.ram_o_ready}, {31'b0, m_cycles >= DEPTH});
    chk("rdat", dut_rdat(), {m_rdat[3], m_rdat[2], m_rdat[1], m_rdat[0]});
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rvalid"}, {31'b0, bus.ram_o_rvalid}, 32'h0);
    chk({tag, "_err"}, {31'b0, bus.ram_o_err}, 32'h0);
    chk({tag, "_ready"}, {31'b0, bus.ram_o_ready}, 32'h0);
    chk({tag, "_rdat"}, dut_rdat(), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'hF, 8'h00, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 4'hF, 8'h14, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, 8'hFC, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 8'h10, 32'hDDCCBBAA, 1'b0, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, 8'h10, 32'h0,        1'b1, 1'b0, 32'hDDCCBBAA};
    vecs[5]  = '{1'b1, 1'b0, 4'h1, 8'h13, 32'h0,        1'b1, 1'b0, 32'h000000DD};
    vecs[6]  = '{1'b1, 1'b1, 4'h1, 8'h21, 32'h0000005A, 1'b0, 1'b0, 32'h000000DD};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 8'h20, 32'h0,        1'b1, 1'b0, 32'h00005A00};
    vecs[8]  = '{1'b1, 1'b1, 4'h3, 8'h23, 32'h00001111, 1'b0, 1'b1, 32'h00005A00};
    vecs[9]  = '{1'b1, 1'b0, 4'hF, 8'h24, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 8'h22, 32'h11223344, 1'b0, 1'b1, 32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 8'h20, 32'h0,        1'b1, 1'b0, 32'h00005A00};
    vecs[12] = '{1'b1, 1'b0, 4'hF, 8'h30, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0,        1'b0, 1'b0, 32'h00000000};
    vecs[14] = '{1'b1, 1'b1, 4'hF, 8'h40, 32'h01020304, 1'b0, 1'b0, 32'h00000000};
    vecs[15] = '{1'b1, 1'b0, 4'hF, 8'h40, 32'h0,        1'b1, 1'b0, 32'h01020304};
    vecs[16] = '{1'b1, 1'b0, 4'h3, 8'h42, 32'h0,        1'b1, 1'b0, 32'h00000102};

    bus.ram_i_cs = 1'b0; bus.ram_i_wen = 1'b0; bus.ram_i_mask = 4'h0; bus.ram_i_addr = '0;
    bus.ram_i_wdat0 = 8'h0; bus.ram_i_wdat1 = 8'h0; bus.ram_i_wdat2 = 8'h0; bus.ram_i_wdat3 = 8'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Zero-fill window; the store at cycle 3 must be ignored.
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 3) do_req(1'b1, 1'b1, 4'hF, 8'h30, 32'hFFFFFFFF);
      else        do_req(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    end

    foreach (vecs[i]) begin
      do_req(vecs[i].cs, vecs[i].wen, vecs[i].mask, vecs[i].addr, vecs[i].wdat);
      chk($sformatf("vec%0d_rvalid", i), {31'b0, bus.ram_o_rvalid}, {31'b0, vecs[i].rv});
      chk($sformatf("vec%0d_err", i), {31'b0, bus.ram_o_err}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d_rdat", i), dut_rdat(), vecs[i].rdat);
    end

    // Reset in the second cycle of a back-to-back load stream.
    do_req(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    bus.ram_i_addr = 8'h14;
    @(posedge clk);
    #1;
    chk("stream_rv2", {31'b0, bus.ram_o_rvalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    bus.ram_i_cs = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) do_req(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    do_req(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    chk("post_reset_data", dut_rdat(), 32'h0);

    for (int i = 0; i < 400; i++) begin
      do_req($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 63)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
